// File: rtl/derivador_pipe.sv
// Pipelined lag-D differentiator: dk = round(Kd * (y[n] - y[n-D]) / 2^F), 2-cycle latency.
// Build option DERIV_SAT_EN: saturate dk and flag sat; otherwise two's-complement wrap.
module derivador_pipe #(
  parameter int W = 12,
  parameter int F = 0,
  parameter int D = 1
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Enable,
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] Kd,
  output logic signed [W-1:0] dk,
  output logic                dk_valid,
  output logic                primed,
  output logic                sat
);

  localparam int PW = 2*W + 1;
  localparam int CW = $clog2(D + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(D);

  logic signed [W-1:0]  hist [D];
  logic [CW-1:0]        cnt;
  logic signed [W:0]    diff_s1;
  logic signed [W-1:0]  kd_s1;
  logic                 v_s1;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rnd;
  logic signed [PW-1:0] r_s2;
  logic                 v_s2;
  logic signed [W-1:0]  fit_dk;
  logic                 fit_sat;

  assign primed = (cnt == CNT_FULL);

  // Stage 1: exact difference against the oldest history entry, gain capture
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < D; i++) hist[i] <= '0;
      cnt     <= '0;
      diff_s1 <= '0;
      kd_s1   <= '0;
      v_s1    <= 1'b0;
    end else begin
      v_s1 <= Enable & primed;
      if (Enable) begin
        diff_s1 <= {y[W-1], y} - {hist[D-1][W-1], hist[D-1]};
        kd_s1   <= Kd;
        hist[0] <= y;
        for (int i = 1; i < D; i++) hist[i] <= hist[i-1];
        if (!primed) cnt <= cnt + CW'(1);
      end
    end
  end

  assign prod = PW'(diff_s1) * PW'(kd_s1);

  // Adding half an LSB before the arithmetic shift rounds ties toward +inf
  generate
    if (F == 0) begin : g_int_gain
      assign rnd = prod;
    end else begin : g_frac_gain
      localparam logic signed [PW-1:0] HALF = PW'(1) << (F - 1);
      assign rnd = (prod + HALF) >>> F;
    end
  endgenerate

`ifdef DERIV_SAT_EN
  localparam logic signed [PW-1:0] DK_MAX = PW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] DK_MIN = ~DK_MAX;

  always_comb begin
    fit_dk  = r_s2[W-1:0];
    fit_sat = 1'b0;
    if (r_s2 > DK_MAX) begin
      fit_dk  = DK_MAX[W-1:0];
      fit_sat = 1'b1;
    end else if (r_s2 < DK_MIN) begin
      fit_dk  = DK_MIN[W-1:0];
      fit_sat = 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^r_s2[PW-1:W];

  always_comb begin
    fit_dk  = r_s2[W-1:0];
    fit_sat = 1'b0;
  end
`endif

  // Stages 2 and 3: product/rounding register, then output fit
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_s2     <= '0;
      v_s2     <= 1'b0;
      dk       <= '0;
      dk_valid <= 1'b0;
      sat      <= 1'b0;
    end else begin
      v_s2     <= v_s1;
      dk_valid <= v_s2;
      if (v_s1) r_s2 <= rnd;
      if (v_s2) begin
        dk  <= fit_dk;
        sat <= fit_sat;
      end
    end
  end

endmodule

// File: tb/tb_derivador_pipe.sv
// Randomized and directed bench for derivador_pipe: three instances (F/D variants) share
// one stimulus stream and are compared against a sample-history reference model.
module tb_derivador_pipe;

  localparam int W = 12;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  logic Enable = 1'b0;
  logic signed [W-1:0] y = '0;
  logic signed [W-1:0] Kd = '0;

  logic signed [W-1:0] dk0, dk1, dk2;
  logic v0, v1, v2, p0, p1, p2, s0, s1, s2;

  always #5 CLK = ~CLK;

  derivador_pipe #(.W(W), .F(0), .D(1)) u0 (
    .CLK(CLK), .Reset(Reset), .Enable(Enable), .y(y), .Kd(Kd),
    .dk(dk0), .dk_valid(v0), .primed(p0), .sat(s0));
  derivador_pipe #(.W(W), .F(8), .D(1)) u1 (
    .CLK(CLK), .Reset(Reset), .Enable(Enable), .y(y), .Kd(Kd),
    .dk(dk1), .dk_valid(v1), .primed(p1), .sat(s1));
  derivador_pipe #(.W(W), .F(0), .D(4)) u2 (
    .CLK(CLK), .Reset(Reset), .Enable(Enable), .y(y), .Kd(Kd),
    .dk(dk2), .dk_valid(v2), .primed(p2), .sat(s2));

  typedef struct {
    int inst;
    int due;
    int dkv;
    bit satv;
  } ev_t;

  int     ds [3] = '{1, 1, 4};
  int     fs [3] = '{0, 8, 0};
  ev_t    exq [$];
  longint acc_y [$];
  int     n_acc;
  int     cyc;
  int     last_dk [3];
  bit     last_sat [3];
  int     pulses0, pulses2;
  int     n_tests = 0;
  int     n_fail = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ideal result: real-valued rounding half toward +inf, then clip or wrap to W bits
  function automatic void expect_dk(input int f, input longint diff, input longint kd,
                                    output int dkv, output bit s);
    longint p, r;
    logic [63:0] rb;
    logic signed [W-1:0] t;
    p = diff * kd;
    if (f == 0) r = p;
    else r = (p + (longint'(1) <<< (f - 1))) >>> f;
`ifdef DERIV_SAT_EN
    if (r > 2047) begin dkv = 2047; s = 1'b1; end
    else if (r < -2048) begin dkv = -2048; s = 1'b1; end
    else begin dkv = int'(r); s = 1'b0; end
    rb = '0; t = '0;
`else
    rb = r;
    t = rb[W-1:0];
    dkv = int'(t);
    s = 1'b0;
`endif
  endfunction

  task automatic model_clear();
    acc_y.delete();
    exq.delete();
    n_acc = 0;
    pulses0 = 0;
    pulses2 = 0;
    for (int i = 0; i < 3; i++) begin
      last_dk[i] = 0;
      last_sat[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int d;
    bit s;
    longint diff;
    cyc++;
    if (Reset && Enable) begin
      for (int i = 0; i < 3; i++) begin
        if (acc_y.size() >= ds[i]) begin
          diff = longint'(y) - acc_y[acc_y.size() - ds[i]];
          expect_dk(fs[i], diff, longint'(Kd), d, s);
          exq.push_back('{inst: i, due: cyc + 2, dkv: d, satv: s});
        end
      end
      acc_y.push_back(longint'(y));
      if (acc_y.size() > 16) void'(acc_y.pop_front());
      n_acc++;
    end
  endtask

  task automatic check_cycle();
    ev_t keep [$];
    bit ev;
    logic gv, gp, gs;
    longint gd;
    for (int i = 0; i < 3; i++) begin
      ev = 1'b0;
      foreach (exq[j]) begin
        if (exq[j].inst == i && exq[j].due == cyc) begin
          ev = 1'b1;
          last_dk[i] = exq[j].dkv;
          last_sat[i] = exq[j].satv;
        end
      end
      case (i)
        0: begin gv = v0; gp = p0; gs = s0; gd = longint'(dk0); end
        1: begin gv = v1; gp = p1; gs = s1; gd = longint'(dk1); end
        default: begin gv = v2; gp = p2; gs = s2; gd = longint'(dk2); end
      endcase
      check_eq($sformatf("dk_valid[u%0d] c%0d", i, cyc), longint'(gv), longint'(ev));
      check_eq($sformatf("dk[u%0d] c%0d", i, cyc), gd, longint'(last_dk[i]));
      check_eq($sformatf("sat[u%0d] c%0d", i, cyc), longint'(gs), longint'(last_sat[i]));
      check_eq($sformatf("primed[u%0d] c%0d", i, cyc), longint'(gp),
               longint'(acc_y.size() >= ds[i]));
    end
    if (v0 === 1'b1) pulses0++;
    if (v2 === 1'b1) pulses2++;
    foreach (exq[j]) if (exq[j].due > cyc) keep.push_back(exq[j]);
    exq = keep;
  endtask

  task automatic step(input bit en, input longint yv, input longint kv);
    Enable = en;
    y = 12'(yv);
    Kd = 12'(kv);
    @(posedge CLK);
    model_edge();
    #1;
    check_cycle();
  endtask

  // Asserts reset mid-cycle, checks outputs clear immediately, holds it over two edges
  task automatic do_reset();
    #2;
    Reset = 1'b0;
    model_clear();
    #1;
    check_cycle();
    step(1'b1, 55, 7);
    step(1'b1, -55, 7);
    Reset = 1'b1;
  endtask

  initial begin
    cyc = 0;
    model_clear();
    do_reset();

    // T1: integer gain, unit lag
    step(1'b1, 10, 150);
    step(1'b1, 20, 150);
    step(1'b0, 0, 150);
    step(1'b0, 0, 150);
    check_eq("T1 dk", longint'(dk0), 1500);
    check_eq("T1 sat", longint'(s0), 0);
    check_eq("T1 pulses", longint'(pulses0), 1);

    // T2: overflow of the output range
    step(1'b1, 0, 150);
    step(1'b1, 100, 150);
    step(1'b0, 0, 150);
    step(1'b0, 0, 150);
`ifdef DERIV_SAT_EN
    check_eq("T2 dk", longint'(dk0), 2047);
    check_eq("T2 sat", longint'(s0), 1);
`else
    check_eq("T2 dk", longint'(dk0), -1384);
    check_eq("T2 sat", longint'(s0), 0);
`endif

    // T3: fractional gain 0.5, ties round toward +inf
    step(1'b1, 0, 128);
    step(1'b1, 3, 128);
    step(1'b1, 0, 128);
    step(1'b0, 0, 128);
    check_eq("T3 dk half up", longint'(dk1), 2);
    step(1'b0, 0, 128);
    check_eq("T3 dk neg half", longint'(dk1), -1);

    // T4: lag 4, priming
    do_reset();
    step(1'b1, 1, 1);
    step(1'b1, 2, 1);
    step(1'b1, 3, 1);
    check_eq("T4 primed after 3", longint'(p2), 0);
    step(1'b1, 4, 1);
    check_eq("T4 primed after 4", longint'(p2), 1);
    step(1'b1, 5, 1);
    step(1'b1, 9, 1);
    step(1'b0, 0, 1);
    check_eq("T4 dk first", longint'(dk2), 4);
    step(1'b0, 0, 1);
    check_eq("T4 dk second", longint'(dk2), 7);
    step(1'b0, 0, 1);
    check_eq("T4 pulses", longint'(pulses2), 2);

    // T5: random samples, gains and enable gaps
    do_reset();
    for (int k = 0; k < 400; k++) begin
      longint yv, kv;
      yv = longint'($urandom_range(0, 4095)) - 2048;
      if ($urandom_range(0, 3) == 0) kv = longint'($urandom_range(0, 4095)) - 2048;
      else kv = longint'($urandom_range(0, 64)) - 32;
      step($urandom_range(0, 2) != 0, yv, kv);
    end
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    check_eq("T5 pulse count", longint'(pulses0), longint'(n_acc - 1));

    // T6: reset with a result in flight, then re-priming
    step(1'b1, 100, 9);
    step(1'b1, -300, 9);
    step(1'b0, 0, 9);
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, longint'(k * 11), 3);
    step(1'b0, 0, 3);
    step(1'b0, 0, 3);
    check_eq("T6 no pulse before D+1", longint'(pulses2), 0);
    check_eq("T6 primed", longint'(p2), 1);
    step(1'b1, 200, 3);
    step(1'b0, 0, 3);
    step(1'b0, 0, 3);
    check_eq("T6 first pulse", longint'(pulses2), 1);
    check_eq("T6 dk", longint'(dk2), 600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
